full_adder_8bit: RTL and testbench

8-bit binary adder with carry-in and carry-out, built as a ripple chain of 1-bit full-adder cells.
- Primary outputs sum and c_out are purely combinational; they are the architectural result consumed by downstream datapath logic.
- A one-stage output register, on a single clock with asynchronous active-low reset, provides registered copies plus a signed-overflow flag for timing-closed consumers.

---
 rtl/full_adder_8bit.sv | 61 ++++++
 tb/tb_full_adder_8bit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_8bit.sv
// Ripple-carry adder built from WIDTH full-adder cells, with combinational sum/carry outputs
// and a one-stage registered copy that also carries a two's-complement overflow flag.
module full_adder_8bit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic [WIDTH-1:0] sum_q,
   output logic             c_out_q,
   output logic             ovf_q
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_bits;
   logic             ovf;

   logic [WIDTH-1:0] sum_d;
   logic             c_out_d;
   logic             ovf_d;

   // Chain evaluated in one process so the carry vector is a single ordered ripple.
   always_comb begin
      carry    = '0;
      sum_bits = '0;
      carry[0] = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign sum   = sum_bits;
   assign c_out = carry[WIDTH];

   // Carry into the MSB disagreeing with carry out of it means the signed result wrapped.
   assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

   always_comb begin
      sum_d   = sum_bits;
      c_out_d = carry[WIDTH];
      ovf_d   = ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_full_adder_8bit.sv
// Directed self-checking bench for full_adder_8bit: corners, wrap, exhaustive sweep,
// registered overflow, register latency and asynchronous reset.
`timescale 1ns / 100ps
module tb_full_adder_8bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       c_in;
   logic [7:0] sum;
   logic       c_out;
   logic [7:0] sum_q;
   logic       c_out_q;
   logic       ovf_q;

   int errors = 0;
   int checks = 0;

   full_adder_8bit #(
      .WIDTH(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .c_in   (c_in),
      .sum    (sum),
      .c_out  (c_out),
      .sum_q  (sum_q),
      .c_out_q(c_out_q),
      .ovf_q  (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic after_posedge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a     = 8'd100;
      b     = 8'd30;
      c_in  = 1'b0;
      #1;
      checks++;
      if ({ovf_q, c_out_q, sum_q} !== 10'd0) begin
         errors++;
         $display("FAIL reset_regs: got ovf=%b c=%b sum=%0d, want 0 0 0", ovf_q, c_out_q, sum_q);
      end
      after_posedge();
      checks++;
      if (sum_q !== 8'd0) begin
         errors++;
         $display("FAIL reset_hold: got sum_q=%0d, want 0", sum_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      after_posedge();
      checks++;
      if (sum_q !== 8'd130 || c_out_q !== 1'b0) begin
         errors++;
         $display("FAIL first_capture: got sum_q=%0d c_out_q=%b, want 130 0", sum_q, c_out_q);
      end
   endtask

   task automatic test_corners();
      // a, b, c_in, expected sum, expected c_out
      logic [7:0] ta [7] = '{8'd0, 8'd1, 8'd100, 8'd64, 8'd255, 8'd255, 8'd255};
      logic [7:0] tb [7] = '{8'd0, 8'd1, 8'd30, 8'd1, 8'd1, 8'd1, 8'd255};
      logic       tc [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [7:0] es [7] = '{8'd0, 8'd3, 8'd130, 8'd66, 8'd0, 8'd1, 8'd255};
      logic       ec [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         a    = ta[i];
         b    = tb[i];
         c_in = tc[i];
         #1;
         checks++;
         if (sum !== es[i] || c_out !== ec[i]) begin
            errors++;
            $display("FAIL corner_%0d: %0d+%0d+%0d got sum=%0d c_out=%b, want %0d %b",
                     i, ta[i], tb[i], tc[i], sum, c_out, es[i], ec[i]);
         end
      end
      // Carry-in alone rippling through the whole chain.
      a    = 8'd255;
      b    = 8'd0;
      c_in = 1'b1;
      #1;
      checks++;
      if (sum !== 8'd0 || c_out !== 1'b1) begin
         errors++;
         $display("FAIL cin_ripple: got sum=%0d c_out=%b, want 0 1", sum, c_out);
      end
   endtask

   task automatic test_sweep();
      int mism = 0;
      int first_a = -1;
      int first_b = -1;
      int first_c = -1;
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a    = ia[7:0];
               b    = ib[7:0];
               c_in = ic[0];
               #1;
               if ((32'(sum) + 32'd256 * 32'(c_out)) !== 32'(ia + ib + ic)) begin
                  if (mism == 0) begin
                     first_a = ia;
                     first_b = ib;
                     first_c = ic;
                  end
                  mism++;
               end
            end
         end
      end
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL sweep: got %0d mismatches (first a=%0d b=%0d c_in=%0d), want 0",
                  mism, first_a, first_b, first_c);
      end
   endtask

   task automatic test_overflow();
      @(negedge clk);
      a = 8'd127; b = 8'd1; c_in = 1'b0;
      after_posedge();
      checks++;
      if (ovf_q !== 1'b1 || sum_q !== 8'd128 || c_out_q !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pos: got ovf=%b sum_q=%0d c=%b, want 1 128 0", ovf_q, sum_q, c_out_q);
      end
      @(negedge clk);
      a = 8'd128; b = 8'd128; c_in = 1'b0;
      after_posedge();
      checks++;
      if (ovf_q !== 1'b1 || sum_q !== 8'd0 || c_out_q !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg: got ovf=%b sum_q=%0d c=%b, want 1 0 1", ovf_q, sum_q, c_out_q);
      end
      @(negedge clk);
      a = 8'd5; b = 8'd3; c_in = 1'b0;
      after_posedge();
      checks++;
      if (ovf_q !== 1'b0 || sum_q !== 8'd8 || c_out_q !== 1'b0) begin
         errors++;
         $display("FAIL ovf_none: got ovf=%b sum_q=%0d c=%b, want 0 8 0", ovf_q, sum_q, c_out_q);
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      a = 8'd10; b = 8'd20; c_in = 1'b1;
      #1;
      checks++;
      if (sum_q !== 8'd8) begin
         errors++;
         $display("FAIL latency_before: got sum_q=%0d, want 8", sum_q);
      end
      after_posedge();
      checks++;
      if (sum_q !== 8'd31 || c_out_q !== 1'b0) begin
         errors++;
         $display("FAIL latency_after: got sum_q=%0d c=%b, want 31 0", sum_q, c_out_q);
      end
      #1;
      a = 8'd200; b = 8'd100; c_in = 1'b0;
      #1;
      checks++;
      if (sum_q !== 8'd31 || c_out_q !== 1'b0 || sum !== 8'd44) begin
         errors++;
         $display("FAIL latency_hold: got sum_q=%0d c=%b sum=%0d, want 31 0 44",
                  sum_q, c_out_q, sum);
      end
      after_posedge();
      checks++;
      if (sum_q !== 8'd44 || c_out_q !== 1'b1) begin
         errors++;
         $display("FAIL latency_next: got sum_q=%0d c=%b, want 44 1", sum_q, c_out_q);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a = 8'd127; b = 8'd3; c_in = 1'b0;
      after_posedge();
      checks++;
      if (sum_q !== 8'd130 || ovf_q !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got sum_q=%0d ovf=%b, want 130 1", sum_q, ovf_q);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ovf_q, c_out_q, sum_q} !== 10'd0) begin
         errors++;
         $display("FAIL async_clear: got ovf=%b c=%b sum_q=%0d, want 0 0 0", ovf_q, c_out_q, sum_q);
      end
      a = 8'd200; b = 8'd100; c_in = 1'b0;
      #1;
      checks++;
      if (sum !== 8'd44 || c_out !== 1'b1) begin
         errors++;
         $display("FAIL comb_in_reset: got sum=%0d c_out=%b, want 44 1", sum, c_out);
      end
      after_posedge();
      checks++;
      if (sum_q !== 8'd0 || c_out_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: got sum_q=%0d c=%b, want 0 0", sum_q, c_out_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      after_posedge();
      checks++;
      if (sum_q !== 8'd44 || c_out_q !== 1'b1 || ovf_q !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got sum_q=%0d c=%b ovf=%b, want 44 1 0", sum_q, c_out_q, ovf_q);
      end
   endtask

   initial begin
      test_reset();
      test_corners();
      test_sweep();
      test_overflow();
      test_latency();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
